// File: rtl/sdc_pkg.sv
// Shared definitions for the SD-card write path: sequencer states,
// per-lane tick arithmetic and framing tick counts.
package sdc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_CRC,
    ST_STOP,
    ST_BUSY
  } state_e;

  // Framing bits occupy one tick each on every lane.
  localparam int unsigned START_TICKS = 1;
  localparam int unsigned STOP_TICKS  = 1;

  // Ticks needed to move one byte across the active lanes.
  function automatic int unsigned tpb(input int unsigned bus_width);
    return 8 / bus_width;
  endfunction

  // Ticks needed for the whole payload of one block.
  function automatic int unsigned data_ticks(input int unsigned bus_width,
                                             input int unsigned block_bytes);
    return block_bytes * tpb(bus_width);
  endfunction

endpackage

// File: rtl/sdc_tick_counter.sv
// Up-counter with enable and synchronous clear; clear has priority.
module sdc_tick_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  // Count enabled ticks; clear wins over enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_q + WIDTH'(1);
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sdc_block_sequencer.sv
// Bit/byte/block sequencer for the SD-card write path: frames each block as
// start bit, payload, CRC and stop bit, then waits for card busy to clear.
module sdc_block_sequencer
  import sdc_pkg::*;
#(
  parameter int unsigned BUS_WIDTH   = 1,
  parameter int unsigned BLOCK_BYTES = 512,
  parameter int unsigned CRC_BITS    = 16
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  input  logic [15:0] numBlocks,
  input  logic        advance,
  input  logic        abort,
  input  logic        busyLine,
  output logic        shift,
  output logic        load,
  output logic        byteDone,
  output logic        startBit,
  output logic        dataPhase,
  output logic        crcPhase,
  output logic        stopBit,
  output logic        blockDone,
  output logic        allDone,
  output logic        aborted,
  output logic        active,
  output logic [15:0] blocksSent
);

  localparam int unsigned TPB        = tpb(BUS_WIDTH);
  localparam int unsigned DATA_TICKS = data_ticks(BUS_WIDTH, BLOCK_BYTES);
  localparam int unsigned MAX_TICKS  = (DATA_TICKS > CRC_BITS) ? DATA_TICKS : CRC_BITS;
  localparam int unsigned TC_W       = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  localparam logic [TC_W-1:0] DATA_LAST = TC_W'(DATA_TICKS - 1);
  localparam logic [TC_W-1:0] CRC_LAST  = TC_W'(CRC_BITS - 1);
  localparam logic [TC_W-1:0] BYTE_MASK = TC_W'(TPB - 1);

  state_e      state_q, state_d;
  logic [15:0] blocks_q, blocks_d;
  logic [15:0] count_q, count_d;
  logic        aborted_q, aborted_d;
  logic        all_done_q, all_done_d;
  logic [TC_W-1:0] tc;
  logic        tc_en, tc_clr;
  logic        byte_last;

  // tc restarts on every state change and only counts inside DATA/CRC.
  assign tc_en  = advance & ((state_q == ST_DATA) | (state_q == ST_CRC));
  assign tc_clr = (state_d != state_q);

  sdc_tick_counter #(
    .WIDTH(TC_W)
  ) u_tc (
    .clk_i (clk),
    .rst_ni(resetN),
    .en_i  (tc_en),
    .clr_i (tc_clr),
    .cnt_o (tc)
  );

  // State, block bookkeeping and the registered completion pulse.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= ST_IDLE;
      blocks_q   <= '0;
      count_q    <= '0;
      aborted_q  <= 1'b0;
      all_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      blocks_q   <= blocks_d;
      count_q    <= count_d;
      aborted_q  <= aborted_d;
      all_done_q <= all_done_d;
    end
  end

  // Next-state: start only from IDLE, abort from anywhere else, BUSY ignores advance.
  always_comb begin
    state_d    = state_q;
    blocks_d   = blocks_q;
    count_d    = count_q;
    aborted_d  = aborted_q;
    all_done_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start) begin
        state_d   = ST_START;
        count_d   = (numBlocks == '0) ? 16'd1 : numBlocks;
        blocks_d  = '0;
        aborted_d = 1'b0;
      end
    end else if (abort) begin
      state_d    = ST_IDLE;
      aborted_d  = 1'b1;
      all_done_d = 1'b1;
    end else begin
      case (state_q)
        ST_START: if (advance) state_d = ST_DATA;
        ST_DATA:  if (advance && tc == DATA_LAST) state_d = ST_CRC;
        ST_CRC:   if (advance && tc == CRC_LAST) state_d = ST_STOP;
        ST_STOP: begin
          if (advance) begin
            state_d  = ST_BUSY;
            blocks_d = blocks_q + 16'd1;
          end
        end
        ST_BUSY: begin
          if (busyLine) begin
            if (blocks_q < count_q) begin
              state_d = ST_START;
            end else begin
              state_d    = ST_IDLE;
              all_done_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign byte_last = ((tc & BYTE_MASK) == BYTE_MASK);

  assign startBit   = (state_q == ST_START);
  assign dataPhase  = (state_q == ST_DATA);
  assign crcPhase   = (state_q == ST_CRC);
  assign stopBit    = (state_q == ST_STOP);
  assign active     = (state_q != ST_IDLE);
  assign shift      = advance & (startBit | dataPhase | crcPhase | stopBit);
  assign load       = advance & (startBit | (dataPhase & byte_last & (tc != DATA_LAST)));
  assign byteDone   = advance & dataPhase & byte_last;
  assign blockDone  = advance & stopBit;
  assign allDone    = all_done_q;
  assign aborted    = aborted_q;
  assign blocksSent = blocks_q;

endmodule

// File: doc/sdc_block_sequencer.md
# sdc_block_sequencer

Parametrised bit/byte/block sequencer for the FPGA-to-SD-card write path. It succeeds the fixed single-lane, single-block bit counter. It supports 1- or 4-lane data buses, configurable block and CRC lengths, and multi-block writes with card-busy waiting and abort. It sits between the write controller, which issues `start`/`advance`, and the data serializer and CRC generator, which consume `shift`/`load`/phase strobes.

## Interface
- `BUS_WIDTH`, default 1: number of DAT lanes; legal values are 1 or 4.
- `BLOCK_BYTES`, default 512: payload bytes per block; must be at least 1.
- `CRC_BITS`, default 16: CRC ticks per lane.
- `clk` in 1: sole clock, rising edge.
- `resetN` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; honoured only in IDLE.
- `numBlocks` in 16: block count, latched on accepted `start`; 0 is treated as 1.
- `advance` in 1: bit-tick enable; the sequencer moves only on cycles with `advance`=1, except in BUSY and on abort.
- `abort` in 1: terminate the transfer.
- `busyLine` in 1: sampled DAT0 level; 0 means the card is busy.
- `shift` out 1: serializer shift enable.
- `load` out 1: serializer parallel load.
- `byteDone` out 1: last tick of a payload byte.
- `startBit`, `dataPhase`, `crcPhase`, `stopBit` out 1 each: phase indicators.
- `blockDone` out 1: pulse on the stop-bit tick.
- `allDone` out 1: one-cycle completion pulse.
- `aborted` out 1: level flag; set on abort, cleared on the next accepted `start`.
- `active` out 1: high whenever the state is not IDLE.
- `blocksSent` out 16: count of completed blocks.

## Operation
- Derived constants:
  - TPB = 8/BUS_WIDTH ticks per byte.
  - DATA_TICKS = BLOCK_BYTES·TPB.
- States: IDLE → START → DATA → CRC → STOP → BUSY → (START | IDLE).
- IDLE: an accepted `start` latches `numBlocks`, clears `blocksSent` and `aborted`, and moves to START on the next cycle.
- START: one `advance` tick, then DATA.
- DATA: the tick counter `tc` runs 0..DATA_TICKS-1; on the tick with `tc`=DATA_TICKS-1, move to CRC.
- CRC: `tc` runs 0..CRC_BITS-1, then STOP.
- STOP: one tick. `blocksSent` increments on that tick; then BUSY.
- BUSY: ignores `advance`. Exits on the first rising edge with `busyLine`=1:
  - if `blocksSent` < latched count, go to START;
  - otherwise go to IDLE and pulse `allDone`.
- `tc` clears on every state change.
- Output decode is combinational from state, `tc` and `advance`:
  - `shift` = `advance` & state∈{START, DATA, CRC, STOP}.
  - `load` = `advance` & ((state=START) | (state=DATA & `tc` mod TPB = TPB-1 & `tc` ≠ DATA_TICKS-1)).
  - `byteDone` = `advance` & state=DATA & `tc` mod TPB = TPB-1.
  - `blockDone` = `advance` & state=STOP.
  - Phase outputs are levels equal to state decode and are not qualified by `advance`.
- abort, in any non-IDLE state: go to IDLE next cycle, set `aborted`, pulse `allDone`, and hold `blocksSent`. In IDLE, `abort` is ignored.
- abort and `start` in the same IDLE cycle: `start` wins.
- `start` outside IDLE is ignored. It has no effect on the latched count.
- The counter is wide enough for max(DATA_TICKS, CRC_BITS). `blocksSent` is 16 bits; the latched count bounds it, so it never wraps.

## Timing
- All outputs are 0 after reset; the state is IDLE.
- Reset mid-transfer returns to IDLE immediately, with no `allDone` pulse.
- `start` → START is visible 1 cycle later.
- With `advance` held at 1, a block is 1 + DATA_TICKS + CRC_BITS + 1 cycles before BUSY:
  - 4114 cycles for the defaults;
  - 1042 cycles for BUS_WIDTH=4.
- BUSY takes at least 1 cycle, even if `busyLine` is already 1.
- `allDone` is asserted the cycle the state returns to IDLE.

## Structure
- The shared package `sdc_pkg` holds:
  - the state enum;
  - the TPB and DATA_TICKS localparam functions;
  - the start/stop tick constants, shared with the serializer and CRC blocks.
- One sub-module, `sdc_tick_counter`: a parametrised-width counter with enable and synchronous clear, and async active-low reset. It is instantiated once for `tc`. `blocksSent` is an inline register.

## Test plan
- Defaults, `numBlocks`=1, `advance`=1, `busyLine`=1 → 512 `byteDone` pulses, 512 `load` pulses (1 in START plus 511 in DATA), `blockDone` at cycle 4114 after START entry, `allDone` 1 cycle after BUSY, `blocksSent`=1.
- BUS_WIDTH=4, `numBlocks`=3, `busyLine` held 0 for 20 cycles after each STOP → BUSY lasts 20 cycles each time, 3 `blockDone` pulses, `blocksSent`=3, single `allDone`.
- `advance` toggling 1/0 → each phase takes exactly twice the cycles; no output strobe fires when `advance`=0.
- `abort` at DATA `tc`=100 of block 2 → IDLE next cycle, `aborted`=1, `allDone` pulse, `blocksSent`=1.
- `numBlocks`=0 → behaves as 1. `start` during DATA is ignored. `start`+`abort` in IDLE → transfer begins.
- `resetN` low during CRC → all outputs 0 asynchronously, no `allDone`; a new `start` afterwards runs a clean block.
